// File: rtl/microwave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : microwave_pkg
//  Description : Shared types and constants for the microwave timer display
//                path. It holds the BCD digit and seven-segment vector types,
//                the segment codes for 0-9 plus blank (bit order {g,f,e,d,c,b,a},
//                active high), and the default seconds-tens reload value used
//                on a minute borrow.
//  Revision    : 1.0 - initial release
// ============================================================================
package microwave_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_BLANK = 7'h00;

  localparam bcd_t SEC_TENS_WRAP_DEFAULT = 4'd5;

endpackage : microwave_pkg
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_7seg
//  Description : Combinational BCD to seven-segment decoder. Codes 10-15 and
//                an asserted blank input both produce an unlit digit.
//  Ports       : digit - BCD input digit
//                blank - force the digit dark
//                seg   - active-high segments {g,f,e,d,c,b,a}
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
  import microwave_pkg::*;
(
  input  bcd_t digit,
  input  logic blank,
  output seg_t seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule : bcd_to_7seg
`default_nettype wire

// File: rtl/timer_digit_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : timer_digit_decoder
//  Description : Keypad-side consumer of the encoder interface. Synchronises
//                the load strobe and 1 Hz tick, shifts keyed digits into an
//                M:SS register, counts it down once per tick while enabled,
//                flags zero and drives three seven-segment digits.
//  Ports       : Clk, Clearn (async active-low reset), D, loadn, pgt_1Hz, En
//                secOnes/secTens/minOnes - BCD time digits
//                zero                    - all digits are 0
//                segSecOnes/segSecTens/segMin - segment drive {g..a}
//  Options     : LEADING_ZERO_BLANK_EN - blank leading zero digits on display
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_digit_decoder
  import microwave_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter bcd_t SEC_TENS_WRAP = SEC_TENS_WRAP_DEFAULT
) (
  input  logic       Clk,
  input  logic       Clearn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       En,
  output logic [3:0] secOnes,
  output logic [3:0] secTens,
  output logic [3:0] minOnes,
  output logic       zero,
  output logic [6:0] segSecOnes,
  output logic [6:0] segSecTens,
  output logic [6:0] segMin
);

  // Synchroniser chains plus one history flop each for edge detection.
  logic [SYNC_STAGES-1:0] r_loadn_sync;
  logic [SYNC_STAGES-1:0] r_tick_sync;
  logic                   r_loadn_hist;
  logic                   r_tick_hist;
  // D travels alongside loadn so the digit used is the one that was present
  // when the synchronised strobe was sampled.
  bcd_t                   r_d_pipe [SYNC_STAGES];

  bcd_t r_sec_ones, r_sec_tens, r_min_ones;

  logic w_load_fall, w_tick_rise, w_zero, w_d_valid;
  bcd_t w_d_sync;

  assign w_d_sync    = r_d_pipe[SYNC_STAGES-1];
  assign w_load_fall = r_loadn_hist & ~r_loadn_sync[SYNC_STAGES-1];
  assign w_tick_rise = ~r_tick_hist & r_tick_sync[SYNC_STAGES-1];
  assign w_d_valid   = (w_d_sync <= 4'd9);
  assign w_zero      = (r_sec_ones == 4'd0) && (r_sec_tens == 4'd0) &&
                       (r_min_ones == 4'd0);

  always_ff @(posedge Clk or negedge Clearn) begin
    if (!Clearn) begin
      r_loadn_sync <= '1;
      r_tick_sync  <= '0;
      r_loadn_hist <= 1'b1;
      r_tick_hist  <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) r_d_pipe[i] <= '0;
    end else begin
      r_loadn_sync <= {r_loadn_sync[SYNC_STAGES-2:0], loadn};
      r_tick_sync  <= {r_tick_sync[SYNC_STAGES-2:0], pgt_1Hz};
      r_loadn_hist <= r_loadn_sync[SYNC_STAGES-1];
      r_tick_hist  <= r_tick_sync[SYNC_STAGES-1];
      r_d_pipe[0]  <= D;
      for (int i = 1; i < SYNC_STAGES; i++) r_d_pipe[i] <= r_d_pipe[i-1];
    end
  end

  // Edges are acted on only in the cycle they are detected, so anything
  // arriving under the wrong En value is dropped rather than queued.
  always_ff @(posedge Clk or negedge Clearn) begin
    if (!Clearn) begin
      r_sec_ones <= '0;
      r_sec_tens <= '0;
      r_min_ones <= '0;
    end else if (w_load_fall && !En) begin
      if (w_d_valid) begin
        r_min_ones <= r_sec_tens;
        r_sec_tens <= r_sec_ones;
        r_sec_ones <= w_d_sync;
      end
    end else if (w_tick_rise && En && !w_zero) begin
      if (r_sec_ones != 4'd0) begin
        r_sec_ones <= r_sec_ones - 4'd1;
      end else begin
        r_sec_ones <= 4'd9;
        if (r_sec_tens != 4'd0) begin
          r_sec_tens <= r_sec_tens - 4'd1;
        end else begin
          // Not zero overall, so the minutes digit is non-zero here.
          r_sec_tens <= SEC_TENS_WRAP;
          r_min_ones <= r_min_ones - 4'd1;
        end
      end
    end
  end

  assign secOnes = r_sec_ones;
  assign secTens = r_sec_tens;
  assign minOnes = r_min_ones;
  assign zero    = w_zero;

  logic w_blank_min, w_blank_tens;
`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank_min  = (r_min_ones == 4'd0);
  assign w_blank_tens = (r_min_ones == 4'd0) && (r_sec_tens == 4'd0);
`else
  assign w_blank_min  = 1'b0;
  assign w_blank_tens = 1'b0;
`endif

  bcd_to_7seg u_seg_sec_ones (.digit(r_sec_ones), .blank(1'b0),         .seg(segSecOnes));
  bcd_to_7seg u_seg_sec_tens (.digit(r_sec_tens), .blank(w_blank_tens), .seg(segSecTens));
  bcd_to_7seg u_seg_min      (.digit(r_min_ones), .blank(w_blank_min),  .seg(segMin));

endmodule : timer_digit_decoder
`default_nettype wire
